// File: rtl/n64_button_event_queue.sv
// n64_button_event_queue: turns polled N64 controller words into an ordered press/release event FIFO.
// Define JOYSTICK_EVENTS_EN to add quantized joystick direction events.
module n64_button_event_queue #(
    parameter int FIFO_DEPTH = 16,
    parameter int DEADZONE   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 button_data,
    input  logic                        enable,
    output logic [7:0]                  evt_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 button_state,
    output logic                        coalesced,
    input  logic                        clear_coalesced
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] BTN_MASK = 16'hFF3F;
`ifdef JOYSTICK_EVENTS_EN
    typedef enum logic [1:0] {IDLE, SCAN_BTN, SCAN_JOY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN_BTN} state_t;
`endif
    state_t state, state_nx;
    logic [31:0] in_reg;
    logic [15:0] in_btn, chg, diff_rev;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] cnt;
    logic [3:0] idx;
    logic [7:0] push_data;
    logic full, pop, room, push, want_push, stall, changed, joy_diff, in_moved, set_co;
    assign in_btn = in_reg[31:16] & BTN_MASK;
    // change mask is stored by event index, so index 0 (A) sits in bit 0
    assign diff_rev = {<<{in_btn ^ button_state}};
    assign changed = (in_btn != button_state) || joy_diff;
`ifdef JOYSTICK_EVENTS_EN
    localparam logic signed [8:0] DZ = 9'(DEADZONE);
    logic signed [8:0] jx, jy;
    logic [1:0] ax, ay;
    logic [3:0] dir, dir_in;
    logic joy_pend;
    assign jx = {in_reg[15], in_reg[15:8]};
    assign jy = {in_reg[7], in_reg[7:0]};
    assign ax = {jx < -DZ, jx > DZ};
    assign ay = {jy < -DZ, jy > DZ};
    always_comb begin
        dir_in = 4'd0;
        case ({ax, ay})
            4'b00_01: dir_in = 4'd1;
            4'b01_01: dir_in = 4'd2;
            4'b01_00: dir_in = 4'd3;
            4'b01_10: dir_in = 4'd4;
            4'b00_10: dir_in = 4'd5;
            4'b10_10: dir_in = 4'd6;
            4'b10_00: dir_in = 4'd7;
            4'b10_01: dir_in = 4'd8;
            default:  dir_in = 4'd0;
        endcase
    end
    assign joy_diff = dir_in != dir;
    assign in_moved = button_data[15:0] != in_reg[15:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= '0;
            joy_pend <= 1'b0;
        end else if (state == IDLE && changed) begin
            dir <= dir_in;
            joy_pend <= joy_diff;
        end
    end
`else
    logic unused_xy;
    assign unused_xy = ^in_reg[15:0];
    assign joy_diff = 1'b0;
    assign in_moved = 1'b0;
`endif
    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) if (chg[i]) idx = 4'(i);
    end
    assign evt_valid = cnt != '0;
    assign full = cnt == DEPTH;
    assign pop = evt_valid && evt_ready;
    assign room = !full || pop;
    assign push = want_push && room;
    assign stall = want_push && !room;
    assign set_co = stall && enable && (((button_data[31:16] & BTN_MASK) != in_btn) || in_moved);
    assign evt_data = evt_valid ? mem[rd_ptr] : '0;
    assign fifo_count = cnt;
    always_comb begin
        state_nx = state;
        want_push = 1'b0;
        push_data = {button_state[4'd15 - idx], 3'b000, idx};
        case (state)
            IDLE: state_nx = changed ? SCAN_BTN : IDLE;
            SCAN_BTN: begin
                want_push = chg != '0;
`ifdef JOYSTICK_EVENTS_EN
                if (chg == '0) state_nx = joy_pend ? SCAN_JOY : IDLE;
            end
            SCAN_JOY: begin
                want_push = 1'b1;
                push_data = {4'b1010, dir};
                state_nx = room ? IDLE : SCAN_JOY;
            end
`else
                if (chg == '0) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            in_reg <= '0;
            chg <= '0;
            button_state <= '0;
            coalesced <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            if (enable) in_reg <= button_data;
            if (state == IDLE && changed) begin
                chg <= diff_rev;
                button_state <= in_btn;
            end else if (push && state == SCAN_BTN) chg[idx] <= 1'b0;
            coalesced <= set_co || (coalesced && !clear_coalesced);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= push_data;
endmodule

// File: tb/tb_n64_button_event_queue.sv
// tb_n64_button_event_queue: directed stimulus against a queue-based event model of the button event queue.
// Joystick expectations follow JOYSTICK_EVENTS_EN the same way the design does.
module tb_n64_button_event_queue;
    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, evt_ready = 1'b1, clear_coalesced = 1'b0;
    logic [31:0] button_data = '0;
    logic [7:0] evt_data;
    logic evt_valid, coalesced;
    logic [2:0] fifo_count;
    logic [15:0] button_state;
    int errors = 0, checks = 0;
    logic [7:0] exp_q[$];
    logic [15:0] m_btn = '0;
`ifdef JOYSTICK_EVENTS_EN
    int m_dir = 0;
    int dir_tab[3][3] = '{'{6, 7, 8}, '{5, 0, 1}, '{4, 3, 2}};
`endif

    n64_button_event_queue #(.FIFO_DEPTH(4), .DEADZONE(16)) dut (
        .clk(clk), .rst_n(rst_n), .button_data(button_data), .enable(enable),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .fifo_count(fifo_count), .button_state(button_state),
        .coalesced(coalesced), .clear_coalesced(clear_coalesced)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef JOYSTICK_EVENTS_EN
    function automatic int axis(input logic [7:0] v);
        int s;
        s = int'($signed(v));
        return s > 16 ? 1 : (s < -16 ? -1 : 0);
    endfunction
`endif

    // Final-state diff against the model's committed controller state.
    task automatic apply(input logic [31:0] w);
        logic [15:0] b;
        b = w[31:16] & 16'hFF3F;
        for (int i = 0; i < 16; i++)
            if (b[15-i] != m_btn[15-i]) exp_q.push_back({b[15-i], 2'b00, 5'(i)});
        m_btn = b;
`ifdef JOYSTICK_EVENTS_EN
        begin
            int d;
            d = dir_tab[axis(w[15:8]) + 1][axis(w[7:0]) + 1];
            if (d != m_dir) exp_q.push_back({4'b1010, 4'(d)});
            m_dir = d;
        end
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] w);
        button_data = w;
        apply(w);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick(1);
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        tick(6);
        check({name, "_idle_valid"}, evt_valid, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("count_bound", fifo_count <= 3'd4, 1'b1);
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) check("unexpected_evt", {1'b1, evt_data}, {1'b0, evt_data});
                else check("evt", evt_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        tick(2);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_data", evt_data, 8'h00);
        check("rst_count", fifo_count, 3'd0);
        check("rst_state", button_state, 16'h0000);
        check("rst_coal", coalesced, 1'b0);
        rst_n = 1'b1;
        tick(2);
        // first-event latency
        put(32'h8000_0000);
        check("model_a", exp_q[0], 8'h80);
        tick(1);
        check("lat_e0", evt_valid, 1'b0);
        tick(1);
        check("lat_e1", evt_valid, 1'b0);
        check("lat_state", button_state, 16'h8000);
        tick(1);
        check("lat_e2_valid", evt_valid, 1'b1);
        check("lat_e2_data", evt_data, 8'h80);
        drain("a");
        put(32'h9000_0000);
        check("model_start", exp_q[0], 8'h83);
        drain("start");
        put(32'h1000_0000);
        check("model_a_rel", exp_q[0], 8'h00);
        drain("a_rel");
        check("state_start", button_state, 16'h1000);
        // reserved bits alone must not produce events
        put(32'h10C0_0000);
        check("model_rsv", exp_q.size(), 0);
        drain("rsv");
        check("state_rsv", button_state, 16'h1000);
        put(32'h0000_0000);
        drain("clr");
        // fill the 4-deep FIFO and change Z while the scanner is stalled
        evt_ready = 1'b0;
        put(32'hFF3F_0000);
        check("model_14", exp_q.size(), 14);
        tick(10);
        check("stall_count", fifo_count, 3'd4);
        check("stall_coal0", coalesced, 1'b0);
        put(32'hDF3F_0000);
        check("model_15", exp_q.size(), 15);
        tick(3);
        check("stall_coal1", coalesced, 1'b1);
        check("stall_count2", fifo_count, 3'd4);
        evt_ready = 1'b1;
        drain("coal");
        check("coal_sticky", coalesced, 1'b1);
        check("coal_state", button_state, 16'hDF3F);
        clear_coalesced = 1'b1;
        tick(1);
        clear_coalesced = 1'b0;
        check("coal_clear", coalesced, 1'b0);
        // frozen sampling
        enable = 1'b0;
        button_data = 32'h0400_0000;
        tick(8);
        check("frz_valid", evt_valid, 1'b0);
        check("frz_state", button_state, 16'hDF3F);
        enable = 1'b1;
        apply(button_data);
        drain("frz");
        check("frz_state2", button_state, 16'h0400);
`ifdef JOYSTICK_EVENTS_EN
        put(32'h0400_8000);
        check("model_w", exp_q[0], 8'hA7);
        drain("joy_w");
        put(32'h0400_1000);
        check("model_ctr", exp_q[0], 8'hA0);
        drain("joy_c");
        put(32'h0400_11EF);
        check("model_se", exp_q[0], 8'hA4);
        drain("joy_se");
`else
        foreach (exp_q[i]) check("stale_q", exp_q[i], 8'h00);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] xy_tab [4];
            xy_tab = '{16'h8000, 16'h7F7F, 16'hEF11, 16'h1111};
            put({16'h0400, xy_tab[i]});
            check("xy_model", exp_q.size(), 0);
            tick(6);
            check("xy_valid", evt_valid, 1'b0);
        end
        put(32'h8400_1111);
        check("model_a2", exp_q[0], 8'h80);
        drain("xy_btn");
`endif
        put(32'h0000_0000);
        drain("clr2");
        // asynchronous reset in the middle of a scan
        evt_ready = 1'b0;
        put(32'hE000_0000);
        tick(3);
        check("pre_rst_count", fifo_count, 3'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", fifo_count, 3'd0);
        check("mid_rst_valid", evt_valid, 1'b0);
        check("mid_rst_state", button_state, 16'h0000);
        exp_q.delete();
        m_btn = '0;
`ifdef JOYSTICK_EVENTS_EN
        m_dir = 0;
`endif
        button_data = 32'h8000_0000;
        evt_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        apply(button_data);
        check("model_a3", exp_q[0], 8'h80);
        drain("post_rst");
        check("final_q", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
